// File: rtl/w_outport_scheduler.sv
// West output port scheduler for a wormhole router node.
//
// Picks one of the north, south, east and local input buffers that target
// west. Selection is round-robin, starting from a rotating pointer. The grant
// is held for the whole packet, head through tail. Downstream credits gate
// every grant.
//
// Ports:
//   clk              clock, rising edge
//   reset            synchronous active-high reset
//   req_i[3:0]       {n,s,e,l} head flit valid and routed west
//   tail_i[3:0]      {n,s,e,l} head flit is a tail flit
//   credit_return_i  downstream freed one slot this cycle
//   grant_o[3:0]     one-hot {n,s,e,l} grant, zero when nothing crosses
//   grant_sel_o[2:0] crossbar select (n=000 s=001 e=011 l=100, idle=010)
//   change_order_o   pulse when a tail flit is granted and the pointer rotates
//   busy_o           high while a packet holds the port
//   credit_cnt_o     registered credit count
//   credit_err_o     sticky: credit returned while the counter was full
module w_outport_scheduler #(
  parameter int unsigned CREDIT_DEPTH = 4,
  parameter int unsigned CNT_W        = $clog2(CREDIT_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       req_i,
  input  logic [3:0]       tail_i,
  input  logic             credit_return_i,
  output logic [3:0]       grant_o,
  output logic [2:0]       grant_sel_o,
  output logic             change_order_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] credit_cnt_o,
  output logic             credit_err_o
);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  // Port index in rotation order: 0=n, 1=s, 2=e, 3=l.
  // Vector bit for index i is bit (3 - i).
  localparam logic [2:0] SelIdle = 3'b010;

  state_e           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic             credit_ok;
  logic             found;
  logic [1:0]       winner;
  logic [1:0]       cand;

  function automatic logic [3:0] idx_onehot(input logic [1:0] idx);
    return 4'b1000 >> idx;
  endfunction

  function automatic logic [2:0] idx_sel(input logic [1:0] idx);
    logic [2:0] sel;
    unique case (idx)
      2'd0:    sel = 3'b000;
      2'd1:    sel = 3'b001;
      2'd2:    sel = 3'b011;
      default: sel = 3'b100;
    endcase
    return sel;
  endfunction

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    owner_d        = owner_q;
    cnt_d          = cnt_q;
    err_d          = err_q;
    grant_o        = 4'b0000;
    grant_sel_o    = SelIdle;
    change_order_o = 1'b0;
    busy_o         = 1'b0;
    found          = 1'b0;
    winner         = ptr_q;
    cand           = ptr_q;

    // Eligibility uses the registered count only; a same-cycle return cannot help.
    credit_ok = (cnt_q != '0);

    unique case (state_q)
      StIdle: begin
        for (int k = 0; k < 4; k++) begin
          cand = ptr_q + 2'(k);
          if (!found && req_i[2'd3 - cand]) begin
            found  = 1'b1;
            winner = cand;
          end
        end
        if (found && credit_ok) begin
          grant_o     = idx_onehot(winner);
          grant_sel_o = idx_sel(winner);
          if (tail_i[2'd3 - winner]) begin
            change_order_o = 1'b1;
            ptr_d          = winner + 2'd1;
          end else begin
            state_d = StLocked;
            owner_d = winner;
          end
        end
      end
      StLocked: begin
        busy_o      = 1'b1;
        // Select keeps pointing at the owner even while stalled.
        grant_sel_o = idx_sel(owner_q);
        if (req_i[2'd3 - owner_q] && credit_ok) begin
          grant_o = idx_onehot(owner_q);
          if (tail_i[2'd3 - owner_q]) begin
            change_order_o = 1'b1;
            ptr_d          = owner_q + 2'd1;
            state_d        = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // A grant and a return in the same cycle cancel out.
    if ((|grant_o) && !credit_return_i) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else if (!(|grant_o) && credit_return_i) begin
      if (cnt_q == CNT_W'(CREDIT_DEPTH)) begin
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    if (reset) begin
      grant_o        = 4'b0000;
      grant_sel_o    = SelIdle;
      change_order_o = 1'b0;
      busy_o         = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      ptr_q   <= 2'd0;
      owner_q <= 2'd0;
      cnt_q   <= CNT_W'(CREDIT_DEPTH);
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign credit_cnt_o = cnt_q;
  assign credit_err_o = err_q;

endmodule

// File: tb/tb_w_outport_scheduler.sv
module tb_w_outport_scheduler;

  localparam int unsigned Depth = 4;
  localparam int unsigned CntW  = 3;

  logic            clk;
  logic            reset;
  logic [3:0]      req_i;
  logic [3:0]      tail_i;
  logic            credit_return_i;
  logic [3:0]      grant_o;
  logic [2:0]      grant_sel_o;
  logic            change_order_o;
  logic            busy_o;
  logic [CntW-1:0] credit_cnt_o;
  logic            credit_err_o;

  w_outport_scheduler #(
    .CREDIT_DEPTH(Depth)
  ) u_dut (
    .clk            (clk),
    .reset          (reset),
    .req_i          (req_i),
    .tail_i         (tail_i),
    .credit_return_i(credit_return_i),
    .grant_o        (grant_o),
    .grant_sel_o    (grant_sel_o),
    .change_order_o (change_order_o),
    .busy_o         (busy_o),
    .credit_cnt_o   (credit_cnt_o),
    .credit_err_o   (credit_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] g;
    logic [2:0] sel;
    logic       chg;
    logic       busy;
    logic [2:0] cnt;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model state: port index 0=n,1=s,2=e,3=l.
  bit m_locked, n_locked;
  int m_ptr, n_ptr, m_owner, n_owner, m_cnt, n_cnt;
  bit m_err, n_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [2:0] enc(input int idx);
    case (idx)
      0:       return 3'b000;
      1:       return 3'b001;
      2:       return 3'b011;
      default: return 3'b100;
    endcase
  endfunction

  task automatic model_eval(input logic [3:0] req, input logic [3:0] tail, input bit ret,
                            input bit rst, output exp_t e);
    int  w;
    bit  hit;
    e.g = 4'b0000; e.sel = 3'b010; e.chg = 1'b0; e.busy = 1'b0;
    e.cnt = 3'(m_cnt); e.err = m_err;
    n_locked = m_locked; n_ptr = m_ptr; n_owner = m_owner; n_cnt = m_cnt; n_err = m_err;
    if (rst) begin
      n_locked = 0; n_ptr = 0; n_owner = 0; n_cnt = Depth; n_err = 0;
      return;
    end
    if (!m_locked) begin
      hit = 0;
      w   = 0;
      for (int k = 0; k < 4; k++) begin
        if (!hit && req[3 - ((m_ptr + k) % 4)]) begin
          hit = 1;
          w   = (m_ptr + k) % 4;
        end
      end
      if (hit && m_cnt > 0) begin
        e.g = 4'b0001 << (3 - w);
        e.sel = enc(w);
        if (tail[3 - w]) begin
          e.chg = 1'b1;
          n_ptr = (w + 1) % 4;
        end else begin
          n_locked = 1;
          n_owner  = w;
        end
      end
    end else begin
      e.busy = 1'b1;
      e.sel  = enc(m_owner);
      if (req[3 - m_owner] && m_cnt > 0) begin
        e.g = 4'b0001 << (3 - m_owner);
        if (tail[3 - m_owner]) begin
          e.chg    = 1'b1;
          n_ptr    = (m_owner + 1) % 4;
          n_locked = 0;
        end
      end
    end
    n_cnt = m_cnt - ((e.g != 0) ? 1 : 0) + (ret ? 1 : 0);
    if (n_cnt > Depth) begin
      n_cnt = Depth;
      n_err = 1;
    end
  endtask

  // One clock cycle: drive, predict, sample at negedge, advance model at posedge.
  task automatic cycle(input logic [3:0] req, input logic [3:0] tail, input bit ret,
                       input bit rst, input bit chk);
    exp_t e, o;
    req_i = req; tail_i = tail; credit_return_i = ret; reset = rst;
    model_eval(req, tail, ret, rst, e);
    if (chk) exp_q.push_back(e);
    @(negedge clk);
    if (exp_q.size() > 0) begin
      o = exp_q.pop_front();
      check("grant", 32'(grant_o), 32'(o.g));
      check("sel", 32'(grant_sel_o), 32'(o.sel));
      check("change_order", 32'(change_order_o), 32'(o.chg));
      check("busy", 32'(busy_o), 32'(o.busy));
      check("credit_cnt", 32'(credit_cnt_o), 32'(o.cnt));
      check("credit_err", 32'(credit_err_o), 32'(o.err));
      check("grant_onehot0", 32'($onehot0(grant_o)), 32'd1);
    end
    @(posedge clk);
    m_locked = n_locked; m_ptr = n_ptr; m_owner = n_owner; m_cnt = n_cnt; m_err = n_err;
    #1;
  endtask

  initial begin
    req_i = 4'b0000; tail_i = 4'b0000; credit_return_i = 1'b0; reset = 1'b1;
    m_locked = 0; m_ptr = 0; m_owner = 0; m_cnt = Depth; m_err = 0;

    cycle(4'b0000, 4'b0000, 0, 1, 0);
    cycle(4'b0000, 4'b0000, 0, 1, 1);

    // All request single-flit packets, credits returned each cycle: n,s,e,l.
    for (int i = 0; i < 4; i++) cycle(4'b1111, 4'b1111, 1, 0, 1);
    check("rr_cnt_full", 32'(credit_cnt_o), 32'd4);

    // Single n flit moves the pointer to s, then s 3-flit packet with n waiting.
    cycle(4'b1000, 4'b1000, 1, 0, 1);
    cycle(4'b1100, 4'b0000, 0, 0, 1);
    cycle(4'b1100, 4'b0000, 0, 0, 1);
    cycle(4'b1100, 4'b0100, 0, 0, 1);
    cycle(4'b1000, 4'b1000, 0, 0, 1);
    check("wormhole_cnt_empty", 32'(credit_cnt_o), 32'd0);

    // Return with request at zero credit: no grant now, grant next cycle.
    cycle(4'b0001, 4'b0000, 1, 0, 1);
    check("ret_at_zero_no_grant_cnt", 32'(credit_cnt_o), 32'd1);
    cycle(4'b0001, 4'b0000, 1, 0, 1);  // grant + return at cnt=1
    check("grant_and_ret_cnt", 32'(credit_cnt_o), 32'd1);
    cycle(4'b0001, 4'b0000, 0, 0, 1);
    cycle(4'b0001, 4'b0000, 0, 0, 1);  // stall at zero
    cycle(4'b0001, 4'b0000, 1, 0, 1);
    cycle(4'b0001, 4'b0001, 0, 0, 1);
    for (int i = 0; i < 4; i++) cycle(4'b0000, 4'b0000, 1, 0, 1);

    // Credit exhaustion on a 6-flit packet from l.
    for (int i = 0; i < 4; i++) cycle(4'b0001, 4'b0000, 0, 0, 1);
    cycle(4'b0001, 4'b0000, 0, 0, 1);
    check("exhaust_busy", 32'(busy_o), 32'd1);
    cycle(4'b0001, 4'b0000, 1, 0, 1);
    cycle(4'b0001, 4'b0000, 0, 0, 1);
    cycle(4'b0001, 4'b0000, 1, 0, 1);
    cycle(4'b0001, 4'b0001, 0, 0, 1);
    for (int i = 0; i < 4; i++) cycle(4'b0000, 4'b0000, 1, 0, 1);

    // Overflow at full credit sets the sticky error.
    cycle(4'b0000, 4'b0000, 1, 0, 1);
    for (int i = 0; i < 3; i++) cycle(4'b0000, 4'b0000, 0, 0, 1);
    check("err_sticky", 32'(credit_err_o), 32'd1);

    // Lock on e, reset mid-packet, then n wins from the reset pointer.
    cycle(4'b0010, 4'b0000, 0, 0, 1);
    cycle(4'b0010, 4'b0000, 0, 0, 1);
    cycle(4'b0010, 4'b0000, 0, 1, 1);
    cycle(4'b1010, 4'b0000, 0, 0, 1);
    check("post_reset_grant_n", 32'(grant_o), 32'h8);

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      cycle(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 99) < 35), ($urandom_range(0, 99) < 2), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
